// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit register with hold, load, shift right/left and rotate right.
//   clk, reset (sync, active-high), enable, mode (00 LOAD, 01 SHR, 10 SHL, 11 ROTR),
//   d (parallel data), ser_in_msb/ser_in_lsb (serial inputs) ->
//   q, q_not, ser_out_lsb, ser_out_msb, shift_cnt (saturating), done (one-cycle pulse)
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_not,
  output logic             ser_out_lsb,
  output logic             ser_out_msb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             done
);
  logic [WIDTH-1:0] reg_q, reg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift;
  assign shift = enable && (mode != 2'b00);
  // Shifts are formed on a WIDTH+1 vector and truncated so WIDTH=1 needs no special case.
  always_comb begin
    reg_d  = !enable        ? reg_q :
             mode == 2'b00  ? d :
             mode == 2'b01  ? WIDTH'({ser_in_msb, reg_q} >> 1) :
             mode == 2'b10  ? WIDTH'({reg_q, ser_in_lsb}) :
                              WIDTH'({reg_q[0], reg_q} >> 1);
    cnt_d  = (enable && mode == 2'b00)           ? '0 :
             (shift && cnt_q != CNT_W'(WIDTH))  ? cnt_q + CNT_W'(1) : cnt_q;
    done_d = shift && (cnt_q == CNT_W'(WIDTH-1));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_q  <= RESET_VALUE;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end
  assign q           = reg_q;
  assign q_not       = ~reg_q;
  assign ser_out_lsb = reg_q[0];
  assign ser_out_msb = reg_q[WIDTH-1];
  assign shift_cnt   = cnt_q;
  assign done        = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: checks two univ_shift_reg instances (reset values 00 and 3C) against a model.
module tb_univ_shift_reg;
  logic clk = 0, reset = 0, enable = 0, ser_in_msb = 0, ser_in_lsb = 0;
  logic [1:0] mode = 0;
  logic [7:0] d = 0;
  logic [7:0] q0, qn0, q1, qn1;
  logic [3:0] cnt0, cnt1;
  logic slsb0, smsb0, done0, slsb1, smsb1, done1;
  int checks = 0, failures = 0;
  int mq0, mq1, mcnt;
  logic mdone;
  always #5 clk = ~clk;
  univ_shift_reg dut0 (.clk(clk), .reset(reset), .enable(enable), .mode(mode), .d(d),
    .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb), .q(q0), .q_not(qn0),
    .ser_out_lsb(slsb0), .ser_out_msb(smsb0), .shift_cnt(cnt0), .done(done0));
  univ_shift_reg #(.WIDTH(8), .RESET_VALUE(8'h3C)) dut1 (.clk(clk), .reset(reset),
    .enable(enable), .mode(mode), .d(d), .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb),
    .q(q1), .q_not(qn1), .ser_out_lsb(slsb1), .ser_out_msb(smsb1), .shift_cnt(cnt1),
    .done(done1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int nxt(input int v, input logic [1:0] m, input logic si_m, input logic si_l);
    return m == 2'd1 ? (v / 2) + (si_m ? 128 : 0) :
           m == 2'd2 ? ((v * 2) % 256) + (si_l ? 1 : 0) :
                       (v / 2) + ((v % 2) * 128);
  endfunction
  task automatic step(input logic r, input logic en, input logic [1:0] m, input logic [7:0] dd,
                      input logic si_m, input logic si_l);
    reset = r; enable = en; mode = m; d = dd; ser_in_msb = si_m; ser_in_lsb = si_l;
    @(posedge clk);
    if (r) begin
      mq0 = 0; mq1 = 'h3C; mcnt = 0; mdone = 0;
    end else if (!en) mdone = 0;
    else if (m == 2'd0) begin
      mq0 = dd; mq1 = dd; mcnt = 0; mdone = 0;
    end else begin
      mq0 = nxt(mq0, m, si_m, si_l);
      mq1 = nxt(mq1, m, si_m, si_l);
      mdone = (mcnt == 7);
      if (mcnt < 8) mcnt++;
    end
    #1;
    chk("q0", q0, mq0);
    chk("q_not0", qn0, 255 - mq0);
    chk("ser_out_lsb0", slsb0, mq0 % 2);
    chk("ser_out_msb0", smsb0, mq0 / 128);
    chk("cnt0", cnt0, mcnt);
    chk("done0", done0, mdone);
    chk("q1", q1, mq1);
    chk("q_not1", qn1, 255 - mq1);
    chk("cnt1", cnt1, mcnt);
    chk("done1", done1, mdone);
  endtask
  initial begin
    int pulses;
    step(1, 1, 0, 8'hFF, 1, 1);
    step(1, 1, 0, 8'hFF, 1, 1);
    chk("t1_q", q0, 8'h00);
    chk("t1_qnot", qn0, 8'hFF);
    chk("t1_q_rv", q1, 8'h3C);
    step(0, 1, 0, 8'hA5, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 2'($urandom), (i % 2) ? 8'hFF : 8'h00, 1'($urandom), 1'($urandom));
    chk("t2_hold", q0, 8'hA5);
    step(0, 1, 0, 8'h81, 0, 0);
    chk("t3_lsb_before", slsb0, 1'b1);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 8'($urandom), 0, 1'($urandom));
    chk("t3_q", q0, 8'h00);
    chk("t3_done", done0, 1'b1);
    step(0, 1, 1, 8'($urandom), 0, 1'($urandom));
    chk("t3_sat_cnt", cnt0, 4'd8);
    chk("t3_sat_done", done0, 1'b0);
    step(0, 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 2, 8'($urandom), 1'($urandom), 1);
    chk("t4_q", q0, 8'hFF);
    chk("t4_msb", smsb0, 1'b1);
    step(0, 1, 0, 8'h01, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 3, 8'($urandom), 1'($urandom), 1'($urandom));
    chk("t5_q", q0, 8'h01);
    chk("t5_done", done0, 1'b1);
    step(0, 1, 0, 8'h5A, 0, 0);
    chk("t5_cnt", cnt0, 4'd0);
    step(0, 1, 0, 8'hF0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 2, 8'($urandom), 1'($urandom), 1'($urandom));
    step(1, 1, 2, 8'($urandom), 1'($urandom), 1'($urandom));
    chk("t6_q", q1, 8'h3C);
    chk("t6_qnot", qn1, 8'hC3);
    chk("t6_cnt", cnt1, 4'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 2'($urandom_range(1, 3)), 8'($urandom), 1'($urandom), 1'($urandom));
      pulses += int'(done1);
    end
    chk("t6_pulses", pulses, 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, 2'($urandom),
           8'($urandom), 1'($urandom), 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
